// File: rtl/vec_magnitude_seq_pkg.sv
// Shared types and constants for the sequential vector-magnitude unit.
package vec_mag_pkg;

   // Top-level sequencing states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQ   = 2'd1,
      ROOT = 2'd2,
      PUB  = 2'd3
   } state_t;

   // Operation select encodings.
   localparam logic MODE_MAG = 1'b0;
   localparam logic MODE_SSQ = 1'b1;

   // Result width: x^2 + y^2 of two W-bit operands needs 2W+1 bits.
   function automatic int calc_rw(input int w);
      return 2 * w + 1;
   endfunction

endpackage

// File: rtl/vec_magnitude_seq_if.sv
// Start/busy/done handshake bundle between requester and the magnitude unit.
interface vec_magnitude_seq_if
   import vec_mag_pkg::*;
#(
   parameter int W = 8
);
   localparam int RW = calc_rw(W);

   logic          start;
   logic          mode;
   logic [W-1:0]  x;
   logic [W-1:0]  y;
   logic          busy;
   logic          done;
   logic [RW-1:0] result;

   modport master (output start, mode, x, y, input busy, done, result);
   modport slave  (input start, mode, x, y, output busy, done, result);

endinterface

// File: rtl/vec_magnitude_seq_squarer.sv
// Serial shift-add squarer: one multiplier bit per enabled cycle, LSB first.
// Runs all W steps regardless of operand value so latency never varies.
module serial_squarer #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           en,
   input  logic [W-1:0]   operand,
   output logic [2*W-1:0] square
);
   logic [2*W-1:0] mcand_r;
   logic [W-1:0]   mplier_r;
   logic [2*W-1:0] acc_r;

   // Capture the operand on load, then accumulate one partial product per enabled cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_r  <= '0;
         mplier_r <= '0;
         acc_r    <= '0;
      end else if (load) begin
         mcand_r  <= {{W{1'b0}}, operand};
         mplier_r <= operand;
         acc_r    <= '0;
      end else if (en) begin
         if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
         end else begin
            acc_r <= acc_r;
         end
         mcand_r  <= {mcand_r[2*W-2:0], 1'b0};
         mplier_r <= {1'b0, mplier_r[W-1:1]};
      end else begin
         acc_r <= acc_r;
      end
   end

   assign square = acc_r;

endmodule

// File: rtl/vec_magnitude_seq.sv
// Multi-cycle vector magnitude: floor(sqrt(x^2+y^2)) or x^2+y^2.
// Squaring takes W cycles, the restoring root W+1 cycles, then one publish cycle.
module vec_magnitude_seq
   import vec_mag_pkg::*;
#(
   parameter int W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   vec_magnitude_seq_if.slave  bus
);
   localparam int RW = calc_rw(W);
   localparam int CW = $clog2(W + 2);

   state_t          state_r;
   logic [CW-1:0]   cnt_r;
   logic            mode_r;
   logic            busy_r;
   logic            done_r;
   logic [RW-1:0]   result_r;
   logic [W+2:0]    rem_r;
   logic [W:0]      root_r;

   logic            sq_load_s;
   logic            sq_en_s;
   logic [2*W-1:0]  sqx_s;
   logic [2*W-1:0]  sqy_s;
   logic [RW-1:0]   ssq_s;
   logic [2*W+1:0]  rad_s;
   logic [1:0]      pair_s;
   logic [W+2:0]    rem_sh_s;
   logic [W+2:0]    trial_s;

   // Operands are latched into the squarers on the accept edge only.
   assign sq_load_s = (state_r == IDLE) && bus.start;
   assign sq_en_s   = (state_r == SQ);

   serial_squarer #(.W(W)) u_sq_x (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (sq_load_s),
      .en      (sq_en_s),
      .operand (bus.x),
      .square  (sqx_s)
   );

   serial_squarer #(.W(W)) u_sq_y (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (sq_load_s),
      .en      (sq_en_s),
      .operand (bus.y),
      .square  (sqy_s)
   );

   // Sum of squares, radicand pair selection and the trial subtraction operands.
   always_comb begin
      ssq_s = RW'(sqx_s) + RW'(sqy_s);
      rad_s = {1'b0, ssq_s};
      if (cnt_r <= CW'(W)) begin
         pair_s = rad_s[2 * (W - int'(cnt_r)) +: 2];
      end else begin
         pair_s = 2'b00;
      end
      rem_sh_s = {rem_r[W:0], pair_s};
      trial_s  = {root_r, 2'b01};
   end

   // Sequencer with registered handshake outputs and the inline root datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cnt_r    <= '0;
         mode_r   <= MODE_MAG;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= '0;
         rem_r    <= '0;
         root_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  mode_r  <= bus.mode;
                  busy_r  <= 1'b1;
                  cnt_r   <= '0;
                  rem_r   <= '0;
                  root_r  <= '0;
                  state_r <= SQ;
               end
            end
            SQ: begin
               if (cnt_r == CW'(W - 1)) begin
                  cnt_r   <= '0;
                  state_r <= (mode_r == MODE_SSQ) ? PUB : ROOT;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            ROOT: begin
               if (rem_sh_s >= trial_s) begin
                  rem_r  <= rem_sh_s - trial_s;
                  root_r <= {root_r[W-1:0], 1'b1};
               end else begin
                  rem_r  <= rem_sh_s;
                  root_r <= {root_r[W-1:0], 1'b0};
               end
               if (cnt_r == CW'(W)) begin
                  cnt_r   <= '0;
                  state_r <= PUB;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            PUB: begin
               result_r <= (mode_r == MODE_SSQ) ? ssq_s : RW'(root_r);
               done_r   <= 1'b1;
               busy_r   <= 1'b0;
               state_r  <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.result = result_r;

endmodule

// File: tb/tb_vec_magnitude_seq.sv
// Directed self-checking bench for vec_magnitude_seq with W=8.
module tb_vec_magnitude_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   vec_magnitude_seq_if #(.W(8)) bus ();

   vec_magnitude_seq #(.W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Issue one operation, scramble inputs after accept, wait for done.
   task automatic do_op(input logic m, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [16:0] res, output int busy_bad);
      bus.mode  = m;
      bus.x     = a;
      bus.y     = b;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.x     = ~a;
      bus.y     = b + 8'd1;
      bus.mode  = ~m;
      lat       = -1;
      res       = '0;
      busy_bad  = 0;
      if (bus.busy !== 1'b1) busy_bad++;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            lat = c;
            res = bus.result;
            if (bus.busy !== 1'b0) busy_bad++;
            break;
         end else if (bus.busy !== 1'b1) begin
            busy_bad++;
         end
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      bus.x     = 8'd0;
      bus.y     = 8'd0;
      #12;
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0d want 0", bus.busy); end
      n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0d want 0", bus.done); end
      n_vec++; if (bus.result !== 17'd0) begin n_err++; $display("FAIL reset_result got %0d want 0", bus.result); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mag_basic();
      int lat; logic [16:0] res; int bb;
      do_op(1'b0, 8'd3, 8'd4, lat, res, bb);
      n_vec++; if (lat !== 18) begin n_err++; $display("FAIL mag34_latency got %0d want 18", lat); end
      n_vec++; if (res !== 17'd5) begin n_err++; $display("FAIL mag34_result got %0d want 5", res); end
      n_vec++; if (bb !== 0) begin n_err++; $display("FAIL mag34_busy got %0d bad cycles want 0", bb); end
      @(posedge clk); #1;
      n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL mag34_done_pulse got %0d want 0", bus.done); end
   endtask

   task automatic test_max_operands();
      int lat; logic [16:0] res; int bb;
      do_op(1'b1, 8'd255, 8'd255, lat, res, bb);
      n_vec++; if (lat !== 9) begin n_err++; $display("FAIL ssqmax_latency got %0d want 9", lat); end
      n_vec++; if (res !== 17'd130050) begin n_err++; $display("FAIL ssqmax_result got %0d want 130050", res); end
      n_vec++; if (bb !== 0) begin n_err++; $display("FAIL ssqmax_busy got %0d bad cycles want 0", bb); end
      @(posedge clk); #1;
      do_op(1'b0, 8'd255, 8'd255, lat, res, bb);
      n_vec++; if (lat !== 18) begin n_err++; $display("FAIL magmax_latency got %0d want 18", lat); end
      n_vec++; if (res !== 17'd360) begin n_err++; $display("FAIL magmax_result got %0d want 360", res); end
      @(posedge clk); #1;
      do_op(1'b1, 8'd0, 8'd7, lat, res, bb);
      n_vec++; if (lat !== 9) begin n_err++; $display("FAIL ssq07_latency got %0d want 9", lat); end
      n_vec++; if (res !== 17'd49) begin n_err++; $display("FAIL ssq07_result got %0d want 49", res); end
      @(posedge clk); #1;
   endtask

   task automatic test_boundaries();
      logic [7:0]  xs [4];
      logic [7:0]  ys [4];
      logic [16:0] ex [4];
      int lat; logic [16:0] res; int bb;
      xs = '{8'd0, 8'd1, 8'd5,  8'd255};
      ys = '{8'd0, 8'd1, 8'd12, 8'd0};
      ex = '{17'd0, 17'd1, 17'd13, 17'd255};
      for (int i = 0; i < 4; i++) begin
         do_op(1'b0, xs[i], ys[i], lat, res, bb);
         n_vec++; if (lat !== 18) begin n_err++; $display("FAIL bound%0d_latency got %0d want 18", i, lat); end
         n_vec++; if (res !== ex[i]) begin n_err++; $display("FAIL bound%0d_result got %0d want %0d", i, res, ex[i]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_ignore_start();
      int lat; int ndone; logic [16:0] res;
      lat = -1; ndone = 0; res = '0;
      bus.mode  = 1'b0;
      bus.x     = 8'd6;
      bus.y     = 8'd8;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         if (c == 4) begin
            bus.start = 1'b1;
            bus.x     = 8'd1;
            bus.y     = 8'd1;
            bus.mode  = 1'b1;
         end
         if (c == 6) bus.start = 1'b0;
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            ndone++;
            if (lat < 0) begin
               lat = c;
               res = bus.result;
            end
         end
      end
      n_vec++; if (ndone !== 1) begin n_err++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
      n_vec++; if (lat !== 18) begin n_err++; $display("FAIL ignore_latency got %0d want 18", lat); end
      n_vec++; if (res !== 17'd10) begin n_err++; $display("FAIL ignore_result got %0d want 10", res); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [16:0] res; int bb;
      do_op(1'b0, 8'd3, 8'd4, lat, res, bb);
      n_vec++; if (res !== 17'd5) begin n_err++; $display("FAIL b2b_first_result got %0d want 5", res); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_gap_busy got %0d want 0", bus.busy); end
      bus.mode  = 1'b1;
      bus.x     = 8'd5;
      bus.y     = 8'd12;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_busy got %0d want 1", bus.busy); end
      n_vec++; if (bus.result !== 17'd5) begin n_err++; $display("FAIL b2b_result_hold got %0d want 5", bus.result); end
      lat = -1; res = '0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            lat = c;
            res = bus.result;
            break;
         end
      end
      n_vec++; if (lat !== 9) begin n_err++; $display("FAIL b2b_second_latency got %0d want 9", lat); end
      n_vec++; if (res !== 17'd169) begin n_err++; $display("FAIL b2b_second_result got %0d want 169", res); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_op();
      int lat; logic [16:0] res; int bb; int ndone;
      bus.mode  = 1'b0;
      bus.x     = 8'd6;
      bus.y     = 8'd8;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %0d want 0", bus.busy); end
      n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL midrst_done got %0d want 0", bus.done); end
      n_vec++; if (bus.result !== 17'd0) begin n_err++; $display("FAIL midrst_result got %0d want 0", bus.result); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) ndone++;
      end
      n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL midrst_no_done got %0d pulses want 0", ndone); end
      do_op(1'b0, 8'd7, 8'd24, lat, res, bb);
      n_vec++; if (lat !== 18) begin n_err++; $display("FAIL postrst_latency got %0d want 18", lat); end
      n_vec++; if (res !== 17'd25) begin n_err++; $display("FAIL postrst_result got %0d want 25", res); end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_mag_basic();
      test_max_operands();
      test_boundaries();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
